// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - 24-hour BCD clock with NUM_ALARMS alarm slots, snooze and auto-silence
module multi_alarm_clock #(
  parameter int CLOCK_FREQ   = 10,
  parameter int TICK_FREQ    = 1,
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int AUTO_OFF_SEC = 60,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            h_in1,
  input  logic [3:0]            h_in0,
  input  logic [2:0]            m_in1,
  input  logic [3:0]            m_in0,
  input  logic                  ld_time,
  input  logic                  ld_alarm,
  input  logic [AW-1:0]         alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  stop_alarm,
  input  logic                  snooze,
  output logic [1:0]            h_out1,
  output logic [3:0]            h_out0,
  output logic [2:0]            m_out1,
  output logic [3:0]            m_out0,
  output logic [2:0]            s_out1,
  output logic [3:0]            s_out0,
  output logic                  tick,
  output logic                  alarm,
  output logic [AW-1:0]         alarm_id,
  output logic                  load_err
);
  localparam int DIV       = CLOCK_FREQ / TICK_FREQ;
  localparam int DW        = $clog2(DIV);
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SW        = $clog2(SNZ_TICKS + 1);
  localparam int RW        = $clog2(AUTO_OFF_SEC + 1);
  localparam logic [AW:0] NUM_SLOTS = (AW+1)'(NUM_ALARMS);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  hhmm_t         hm_q, hm_d;
  logic [2:0]    s1_q, s1_d;
  logic [3:0]    s0_q, s0_d;
  hhmm_t         slot_q [NUM_ALARMS];
  hhmm_t         slot_d [NUM_ALARMS];
  logic          upd_q, upd_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          alarm_q, alarm_d;
  logic [AW-1:0] alarm_id_q, alarm_id_d;
  logic          load_err_q, load_err_d;

  hhmm_t         hm_in;
  logic          in_ok, sel_ok, ld_time_ok, ld_alarm_ok, div_last, tick_w, match;
  logic [AW-1:0] win;

  assign hm_in       = {h_in1, h_in0, m_in1, m_in0};
  assign in_ok       = (h_in1 < 2'd2 || (h_in1 == 2'd2 && h_in0 <= 4'd3)) &&
                       h_in0 <= 4'd9 && m_in1 <= 3'd5 && m_in0 <= 4'd9;
  assign sel_ok      = {1'b0, alarm_sel} < NUM_SLOTS;
  assign ld_time_ok  = ld_time && in_ok;
  assign ld_alarm_ok = ld_alarm && in_ok && sel_ok;
  assign div_last    = div_cnt_q == DW'(DIV - 1);
  // An accepted time load restarts the divider, so it swallows a coincident tick.
  assign tick_w      = div_last && !ld_time_ok;

  always_comb begin
    match = 1'b0;
    win   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en[i] && slot_q[i] == hm_q) begin
        match = 1'b1;
        win   = AW'(i);
      end
    end
    match = match && upd_q && s1_q == 3'd0 && s0_q == 4'd0;
  end

  always_comb begin
    div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
    hm_d      = hm_q;
    s1_d      = s1_q;
    s0_d      = s0_q;
    upd_d     = tick_w;
    if (ld_time_ok) begin
      div_cnt_d = '0;
      hm_d      = hm_in;
      s1_d      = '0;
      s0_d      = '0;
    end else if (tick_w) begin
      if (s0_q != 4'd9) s0_d = s0_q + 4'd1;
      else begin
        s0_d = '0;
        if (s1_q != 3'd5) s1_d = s1_q + 3'd1;
        else begin
          s1_d = '0;
          if (hm_q.m0 != 4'd9) hm_d.m0 = hm_q.m0 + 4'd1;
          else begin
            hm_d.m0 = '0;
            if (hm_q.m1 != 3'd5) hm_d.m1 = hm_q.m1 + 3'd1;
            else begin
              hm_d.m1 = '0;
              if (hm_q.h1 == 2'd2 && hm_q.h0 == 4'd3) begin
                hm_d.h1 = '0;
                hm_d.h0 = '0;
              end else if (hm_q.h0 == 4'd9) begin
                hm_d.h0 = '0;
                hm_d.h1 = hm_q.h1 + 2'd1;
              end else hm_d.h0 = hm_q.h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      slot_d[i] = (ld_alarm_ok && alarm_sel == AW'(i)) ? hm_in : slot_q[i];
    end
    load_err_d = (ld_time && !in_ok) || (ld_alarm && !(in_ok && sel_ok));
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    alarm_id_d = alarm_id_q;
    case (state_q)
      IDLE: begin
        if (match) begin
          state_d    = RINGING;
          alarm_id_d = win;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (stop_alarm) state_d = IDLE;
        else if (snooze) begin
          state_d   = SNOOZED;
          snz_cnt_d = SW'(SNZ_TICKS);
        end else if (tick_w) begin
          if (ring_cnt_q == RW'(AUTO_OFF_SEC - 1)) state_d = IDLE;
          else ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      SNOOZED: begin
        if (stop_alarm) state_d = IDLE;
        else if (match) begin
          state_d    = RINGING;
          alarm_id_d = win;
          ring_cnt_d = '0;
        end else if (tick_w) begin
          if (snz_cnt_q == SW'(1)) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else snz_cnt_d = snz_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    alarm_d = (state_d == RINGING);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      hm_q       <= '0;
      s1_q       <= '0;
      s0_q       <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= '0;
      upd_q      <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      alarm_q    <= 1'b0;
      alarm_id_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      hm_q       <= hm_d;
      s1_q       <= s1_d;
      s0_q       <= s0_d;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= slot_d[i];
      upd_q      <= upd_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      alarm_q    <= alarm_d;
      alarm_id_q <= alarm_id_d;
      load_err_q <= load_err_d;
    end
  end

  assign h_out1   = hm_q.h1;
  assign h_out0   = hm_q.h0;
  assign m_out1   = hm_q.m1;
  assign m_out0   = hm_q.m0;
  assign s_out1   = s1_q;
  assign s_out0   = s0_q;
  assign tick     = tick_w;
  assign alarm    = alarm_q;
  assign alarm_id = alarm_id_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - bench for multi_alarm_clock against a seconds-of-day reference model
module tb_multi_alarm_clock;
  localparam int DIV = 10;
  localparam int N   = 5;
  localparam int AW  = 3;
  localparam int SN  = 5;
  localparam int AO  = 60;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] h_in1 = '0;
  logic [3:0] h_in0 = '0;
  logic [2:0] m_in1 = '0;
  logic [3:0] m_in0 = '0;
  logic ld_time = 1'b0, ld_alarm = 1'b0, stop_alarm = 1'b0, snooze = 1'b0;
  logic [AW-1:0] alarm_sel = '0;
  logic [N-1:0]  alarm_en = '0;
  logic [1:0] h_out1;
  logic [3:0] h_out0;
  logic [2:0] m_out1;
  logic [3:0] m_out0;
  logic [2:0] s_out1;
  logic [3:0] s_out0;
  logic tick, alarm, load_err;
  logic [AW-1:0] alarm_id;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: time as seconds of day, slots as minutes of day, state 0/1/2 = idle/ringing/snoozed.
  int r_sec, r_phase, r_state, r_ring, r_snz, r_id, r_err, r_upd;
  int r_slot [N];
  bit r_tick;
  logic dut_tick;

  multi_alarm_clock #(.CLOCK_FREQ(10), .TICK_FREQ(1), .NUM_ALARMS(N),
                      .SNOOZE_MIN(SN), .AUTO_OFF_SEC(AO)) dut (
    .clock(clock), .reset(reset),
    .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1), .m_in0(m_in0),
    .ld_time(ld_time), .ld_alarm(ld_alarm), .alarm_sel(alarm_sel), .alarm_en(alarm_en),
    .stop_alarm(stop_alarm), .snooze(snooze),
    .h_out1(h_out1), .h_out0(h_out0), .m_out1(m_out1), .m_out0(m_out0),
    .s_out1(s_out1), .s_out0(s_out0),
    .tick(tick), .alarm(alarm), .alarm_id(alarm_id), .load_err(load_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_valid();
    return (int'(h_in1) * 10 + int'(h_in0) <= 23) && h_in0 <= 4'd9 && m_in1 <= 3'd5 && m_in0 <= 4'd9;
  endfunction

  function automatic int in_min();
    return (int'(h_in1) * 10 + int'(h_in0)) * 60 + int'(m_in1) * 10 + int'(m_in0);
  endfunction

  function automatic bit model_tick();
    return (r_phase == DIV - 1) && !(ld_time && in_valid());
  endfunction

  task automatic model_reset();
    r_sec = 0; r_phase = 0; r_state = 0; r_ring = 0; r_snz = 0;
    r_id = 0; r_err = 0; r_upd = 0;
    for (int i = 0; i < N; i++) r_slot[i] = 0;
  endtask

  task automatic model_edge();
    bit tv, lt, la, tk, match;
    int win;
    tv = in_valid();
    lt = ld_time && tv;
    la = ld_alarm && tv && (int'(alarm_sel) < N);
    tk = (r_phase == DIV - 1) && !lt;
    match = 0;
    win = 0;
    if (r_upd != 0 && r_sec % 60 == 0)
      for (int i = N - 1; i >= 0; i--)
        if (alarm_en[i] && r_slot[i] == r_sec / 60) begin match = 1; win = i; end
    case (r_state)
      0: if (match) begin r_state = 1; r_id = win; r_ring = 0; end
      1: if (stop_alarm) r_state = 0;
         else if (snooze) begin r_state = 2; r_snz = SN * 60; end
         else if (tk) begin r_ring++; if (r_ring == AO) r_state = 0; end
      default: if (stop_alarm) r_state = 0;
         else if (match) begin r_state = 1; r_id = win; r_ring = 0; end
         else if (tk) begin r_snz--; if (r_snz == 0) begin r_state = 1; r_ring = 0; end end
    endcase
    r_err = ((ld_time && !tv) || (ld_alarm && !(tv && int'(alarm_sel) < N))) ? 1 : 0;
    if (la) r_slot[alarm_sel] = in_min();
    if (lt) begin
      r_sec = in_min() * 60;
      r_phase = 0;
    end else begin
      r_phase = (r_phase + 1) % DIV;
      if (tk) r_sec = (r_sec + 1) % 86400;
    end
    r_upd = tk ? 1 : 0;
  endtask

  task automatic check_all();
    int hrs, mins, secs;
    hrs = r_sec / 3600; mins = (r_sec / 60) % 60; secs = r_sec % 60;
    chk("h_out1", h_out1, hrs / 10);
    chk("h_out0", h_out0, hrs % 10);
    chk("m_out1", m_out1, mins / 10);
    chk("m_out0", m_out0, mins % 10);
    chk("s_out1", s_out1, secs / 10);
    chk("s_out0", s_out0, secs % 10);
    chk("tick", tick, r_tick);
    chk("alarm", alarm, r_state == 1);
    chk("alarm_id", alarm_id, r_id);
    chk("load_err", load_err, r_err);
  endtask

  task automatic cycle();
    @(negedge clock);
    r_tick = model_tick();
    dut_tick = tick;
    check_all();
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic set_in(input int h, input int m);
    h_in1 = 2'(h / 10); h_in0 = 4'(h % 10); m_in1 = 3'(m / 10); m_in0 = 4'(m % 10);
  endtask

  task automatic load_time(input int h, input int m);
    set_in(h, m); ld_time = 1'b1; cycle(); ld_time = 1'b0;
  endtask

  task automatic load_alarm(input int s, input int h, input int m);
    set_in(h, m); alarm_sel = AW'(s); ld_alarm = 1'b1; cycle(); ld_alarm = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen, guard;
    seen = 0; guard = 0;
    while (seen < n && guard < (n + 2) * DIV) begin
      cycle(); guard++;
      if (dut_tick === 1'b1) seen++;
    end
    chk("tick_count_timeout", seen, n);
  endtask

  task automatic measure_period(input string tag);
    int cnt;
    cnt = 0;
    do begin cycle(); cnt++; end while (dut_tick !== 1'b1 && cnt < 4 * DIV);
    chk(tag, cnt, DIV);
  endtask

  task automatic wait_until_hm(input int h, input int m);
    int guard;
    guard = 0;
    while (!(int'(h_out1) * 10 + int'(h_out0) == h && int'(m_out1) * 10 + int'(m_out0) == m &&
             s_out1 == 3'd0 && s_out0 == 4'd0) && guard < 5000) begin
      cycle(); guard++;
    end
    chk("wait_time_timeout", guard < 5000, 1);
  endtask

  task automatic pulse(input bit stp, input bit snz);
    stop_alarm = stp; snooze = snz; cycle(); stop_alarm = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    int h, m, k, act;
    model_reset();
    #12;
    chk("rst_time", {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0}, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_alarm_id", alarm_id, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_tick", tick, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    measure_period("first_tick_latency");

    // Midnight wrap and tick period
    load_time(23, 59);
    wait_ticks(60);
    chk("wrap_time", {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0}, 0);
    measure_period("tick_period_a");
    measure_period("tick_period_b");

    // Ring, then auto-off after AO ticks
    alarm_en = 5'b00100;
    load_alarm(2, 0, 2);
    load_time(0, 1);
    wait_ticks(60);
    chk("ring_not_yet", alarm, 0);
    cycle();
    chk("ring_up", alarm, 1);
    chk("ring_id", alarm_id, 2);
    wait_ticks(AO - 1);
    chk("ring_before_autooff", alarm, 1);
    wait_ticks(1);
    chk("ring_autooff", alarm, 0);

    // Snooze, re-ring, then stop+snooze together
    load_time(0, 1);
    wait_ticks(60);
    cycle();
    chk("snz_ring_up", alarm, 1);
    pulse(1'b0, 1'b1);
    chk("snz_silenced", alarm, 0);
    wait_ticks(SN * 60 - 1);
    chk("snz_still_quiet", alarm, 0);
    wait_ticks(1);
    chk("snz_rering", alarm, 1);
    chk("snz_rering_id", alarm_id, 2);
    pulse(1'b1, 1'b1);
    chk("stop_over_snooze", alarm, 0);
    wait_ticks(SN * 60 + 5);
    chk("stop_stays_idle", alarm, 0);

    // Simultaneous match, then pre-empting a snooze
    load_alarm(1, 7, 30);
    load_alarm(3, 7, 30);
    alarm_en = 5'b01010;
    load_time(7, 29);
    wait_ticks(60);
    cycle();
    chk("multi_ring", alarm, 1);
    chk("multi_lowest_id", alarm_id, 1);
    pulse(1'b0, 1'b1);
    chk("multi_snoozed", alarm, 0);
    load_alarm(3, 7, 32);
    wait_until_hm(7, 32);
    cycle();
    chk("preempt_ring", alarm, 1);
    chk("preempt_id", alarm_id, 3);

    // Asynchronous reset between edges while ringing
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_alarm", alarm, 0);
    chk("async_rst_time", {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0}, 0);
    chk("async_rst_id", alarm_id, 0);
    model_reset();
    cycle();
    cycle();
    reset = 1'b1;
    measure_period("post_reset_first_tick");

    // Rejected loads
    load_time(12, 34);
    set_in(24, 0); ld_time = 1'b1; cycle(); ld_time = 1'b0;
    chk("err_24h", load_err, 1);
    cycle();
    chk("err_24h_pulse_end", load_err, 0);
    set_in(12, 60); ld_time = 1'b1; cycle(); ld_time = 1'b0;
    chk("err_60m", load_err, 1);
    cycle();
    chk("err_60m_pulse_end", load_err, 0);
    chk("err_time_kept_h", {h_out1, h_out0}, {2'd1, 4'd2});
    chk("err_time_kept_m", {m_out1, m_out0}, {3'd3, 4'd4});
    load_alarm(N, 6, 15);
    chk("err_bad_slot", load_err, 1);
    cycle();
    chk("err_bad_slot_end", load_err, 0);

    // Randomized operation
    for (int it = 0; it < 20; it++) begin
      h = int'($urandom_range(0, 23));
      m = int'($urandom_range(0, 58));
      k = int'($urandom_range(0, N - 1));
      load_alarm(k, h, m + 1);
      alarm_en = N'($urandom_range(0, 31)) | (N'(1) << k);
      if ($urandom_range(0, 3) == 0) begin
        set_in(h, m);
        ld_time = 1'b1;
        repeat ($urandom_range(2, 30)) cycle();
        ld_time = 1'b0;
      end else load_time(h, m);
      wait_ticks(int'($urandom_range(55, 70)));
      act = int'($urandom_range(0, 3));
      pulse(act == 0 || act == 3, act == 1 || act == 3);
      wait_ticks(int'($urandom_range(0, 15)));
      h_in1 = 2'($urandom_range(0, 3));
      h_in0 = 4'($urandom_range(0, 15));
      m_in1 = 3'($urandom_range(0, 7));
      m_in0 = 4'($urandom_range(0, 15));
      alarm_sel = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ld_alarm = 1'b1;
      else ld_time = 1'b1;
      cycle();
      ld_alarm = 1'b0;
      ld_time = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised 24-hour BCD real-time clock with NUM_ALARMS independently programmable alarms, snooze and auto-silence. It is the successor of the single-alarm clock block and runs entirely on the system clock, using an internal one-cycle tick enable instead of a derived clock. It feeds the display driver (BCD digit outputs) and the buzzer/indicator logic (`alarm`, `alarm_id`).

## Interface
- CLOCK_FREQ, 10: system clock frequency in Hz.
- TICK_FREQ, 1: timekeeping rate in Hz. DIV = CLOCK_FREQ/TICK_FREQ must be an integer ≥ 2.
- NUM_ALARMS, 4: number of alarm slots, 1..16. AW = max(1, clog2(NUM_ALARMS)).
- SNOOZE_MIN, 5: snooze length in minutes, 1..59.
- AUTO_OFF_SEC, 60: maximum ringing time in seconds before auto-silence, ≥ 1.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- h_in1 / h_in0 / m_in1 / m_in0  in  2/4/3/4  BCD load value, HH:MM.
- ld_time  in  1  level; load clock time from inputs, seconds = 00.
- ld_alarm  in  1  level; load the alarm slot selected by alarm_sel from inputs.
- alarm_sel  in  AW  alarm slot index for ld_alarm.
- alarm_en  in  NUM_ALARMS  per-slot enable, sampled every cycle.
- stop_alarm  in  1  silence and return to idle.
- snooze  in  1  silence and re-ring after SNOOZE_MIN minutes.
- h_out1 / h_out0 / m_out1 / m_out0 / s_out1 / s_out0  out  2/4/3/4/3/4  BCD current time.
- tick  out  1  one-cycle pulse per time step.
- alarm  out  1  high while ringing.
- alarm_id  out  AW  slot that caused the current or last ring.
- load_err  out  1  one-cycle pulse when ld_time or ld_alarm is rejected.

## Operation
- Divider: counter div_cnt runs 0..DIV-1. `tick` is high during the cycle in which div_cnt = DIV-1.
- Timekeeping is BCD only, with no binary intermediate. Carry chain: s0 9→0 carries to s1; s1 5→0 carries to m0; m0 9→0 carries to m1; m1 5→0 carries to hours. Hours wrap 23:59:59 → 00:00:00.
- Load validation: the load is accepted only if h_in1≤2, h_in0≤9, HH≤23, m_in1≤5 and m_in0≤9. A rejected load changes no state and pulses load_err.
- ld_time accepted: time = HH:MM:00 and div_cnt = 0. This has priority over the tick in the same cycle, and `tick` is suppressed in that cycle.
- ld_alarm accepted: slot alarm_sel = HH:MM. If alarm_sel ≥ NUM_ALARMS, the load is rejected.
- Loads are allowed in any FSM state.
- Match: evaluated only in the cycle after a tick-driven time update, when the new time is HH:MM:00, alarm_en[i]=1 and slot i = HH:MM. If several slots match, the lowest index wins.
- FSM states: IDLE, RINGING, SNOOZED.
  - IDLE → RINGING on match. alarm_id = the winning slot, ring_cnt = 0.
  - RINGING: alarm = 1. ring_cnt increments on each tick.
    - stop_alarm → IDLE.
    - else snooze → SNOOZED, with snz_cnt = SNOOZE_MIN*60.
    - else ring_cnt reaching AUTO_OFF_SEC → IDLE.
    - Matches are ignored.
  - SNOOZED: snz_cnt decrements on each tick.
    - stop_alarm → IDLE.
    - snz_cnt reaching 0 → RINGING with ring_cnt = 0 and alarm_id unchanged.
    - A new match → RINGING with the new alarm_id; it pre-empts the snooze.
- stop_alarm has priority over snooze when both are asserted.
- Disabling the ringing slot via alarm_en does not silence a ring already in progress.

## Timing
- Reset values:
  - Time 00:00:00, all alarm slots 00:00, div_cnt 0.
  - FSM in IDLE.
  - tick, alarm, alarm_id and load_err all 0.
- Reset takes effect asynchronously on assertion. The first tick occurs DIV cycles after the first rising edge with reset deasserted.
- Time outputs update on the clock edge that ends the tick cycle.
- `alarm` rises 2 cycles after the tick cycle whose update produced HH:MM:00: one cycle for the time update, one for the registered match/FSM transition.
- stop_alarm and snooze take effect at the next edge, so `alarm` falls 1 cycle after they are sampled.
- Auto-off: `alarm` falls 1 cycle after the tick on which ring_cnt reaches AUTO_OFF_SEC.
- load_err is high for exactly the cycle after the rejected load is sampled.
- Holding ld_time freezes time and div_cnt: no ticks occur while it is held.
- Reset asserted mid-ring or mid-snooze returns to the reset values immediately.

## Test plan
- Wrap: ld_time 23:59, then 60 ticks → outputs 00:00:00; check that tick period = DIV cycles.
- Ring and auto-off: slot 2 = 00:02, en = 4'b0100, ld_time 00:01, 60 ticks → alarm=1 and alarm_id=2 two cycles after the tick; with AUTO_OFF_SEC=60, alarm=0 after 60 further ticks.
- Snooze: ringing, then pulse snooze → alarm=0. alarm=1 again after 300 ticks (SNOOZE_MIN=5) with alarm_id unchanged. Then stop_alarm and snooze together → IDLE.
- Simultaneous match: slots 1 and 3 = 07:30, both enabled → alarm_id=1. A slot-3-only match while slot 1 is snoozed → RINGING with alarm_id=3.
- Invalid loads: ld_time 24:00, ld_time 12:60, and ld_alarm with alarm_sel=NUM_ALARMS → one-cycle load_err pulse each, time and slots unchanged.
- Async reset mid-ring: assert reset between edges → alarm=0 and time 00:00:00 immediately. After release, first tick after DIV cycles.
